// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Single-cycle add/sub/logic/shift ops complete one
// cycle after the start edge; signed multiply and divide iterate one bit per
// cycle behind a start/busy/done handshake. Results and flags are registered
// and held until the next completed operation.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0] i_q,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [4:0]       o_flags
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [4:0]       flags_q, flags_d;
    logic             is_div_q, is_div_d;
    logic             sign_p_q, sign_p_d;
    logic             sign_q_q, sign_q_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    // Single-cycle result path
    logic [WIDTH-1:0]        sc_lo, sc_hi;
    logic [4:0]              sc_flags;
    logic                    sc_cf, sc_of, sc_dz;
    logic [WIDTH:0]          add_ext, sub_ext;
    logic [WIDTH:0]          shl_ext;
    logic signed [WIDTH:0]   shr_ext;
    logic [SHW-1:0]          shamt;
    logic                    sh_big, sh_eq;

    // Iterative datapath helpers
    logic [WIDTH-1:0]   p_mag, q_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_mag, prod_fin;
    logic [WIDTH-1:0]   quo_fin, rem_fin;
    logic               use_iter;

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_lo    = lo_q;
    assign o_hi    = hi_q;
    assign o_flags = flags_q;

    // Evaluate every single-cycle op (and divide-by-zero) from the live inputs.
    always_comb begin
        add_ext  = {1'b0, i_p} + {1'b0, i_q};
        sub_ext  = {1'b0, i_p} - {1'b0, i_q};
        shamt    = i_q[SHW-1:0];
        sh_big   = (i_q[WIDTH-1:SHW] != '0);
        sh_eq    = (i_q == WIDTH'(WIDTH));
        shl_ext  = {1'b0, i_p} << shamt;
        shr_ext  = $signed({i_p, 1'b0}) >>> shamt;
        sc_lo    = '0;
        sc_hi    = '0;
        sc_cf    = 1'b0;
        sc_of    = 1'b0;
        sc_dz    = 1'b0;
        sc_flags = '0;
        case (i_op)
            OP_ADD: begin
                sc_lo = add_ext[WIDTH-1:0];
                sc_cf = add_ext[WIDTH];
                sc_of = (i_p[WIDTH-1] == i_q[WIDTH-1]) && (add_ext[WIDTH-1] != i_p[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo = sub_ext[WIDTH-1:0];
                sc_cf = sub_ext[WIDTH];
                sc_of = (i_p[WIDTH-1] != i_q[WIDTH-1]) && (sub_ext[WIDTH-1] != i_p[WIDTH-1]);
            end
            OP_AND: sc_lo = i_p & i_q;
            OP_OR:  sc_lo = i_p | i_q;
            OP_NOT: sc_lo = ~i_q;
            OP_SHL: begin
                if (sh_big) begin
                    sc_lo = '0;
                    sc_cf = sh_eq ? i_p[0] : 1'b0;
                end else begin
                    sc_lo = shl_ext[WIDTH-1:0];
                    sc_cf = shl_ext[WIDTH];
                end
            end
            OP_SHR: begin
                if (sh_big) begin
                    sc_lo = {WIDTH{i_p[WIDTH-1]}};
                    sc_cf = i_p[WIDTH-1];
                end else begin
                    sc_lo = shr_ext[WIDTH:1];
                    sc_cf = shr_ext[0];
                end
            end
            OP_DIV: begin
                sc_lo = '1;
                sc_hi = i_p;
                sc_dz = 1'b1;
            end
            default: begin
                sc_lo = '0;
                sc_hi = '0;
            end
        endcase
        sc_flags = {({sc_hi, sc_lo} == '0), sc_cf, sc_of, sc_lo[WIDTH-1], sc_dz};
    end

    // One multiply/divide iteration step plus the sign-corrected final values.
    always_comb begin
        p_mag     = i_p[WIDTH-1] ? -i_p : i_p;
        q_mag     = i_q[WIDTH-1] ? -i_q : i_q;
        use_iter  = (i_op == OP_MUL) || ((i_op == OP_DIV) && (i_q != '0));
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, mag_b_q} : '0);
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        prod_mag  = {work_hi_q, work_lo_q};
        prod_fin  = (sign_p_q ^ sign_q_q) ? -prod_mag : prod_mag;
        quo_fin   = (sign_p_q ^ sign_q_q) ? -work_lo_q : work_lo_q;
        rem_fin   = sign_p_q ? -work_hi_q : work_hi_q;
    end

    // Next-state and next-output logic for the IDLE/RUN/FIN/DONE controller.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        lo_d      = lo_q;
        hi_d      = hi_q;
        flags_d   = flags_q;
        is_div_d  = is_div_q;
        sign_p_d  = sign_p_q;
        sign_q_d  = sign_q_q;
        ovf_d     = ovf_q;
        mag_b_d   = mag_b_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (i_start) begin
                    if (use_iter) begin
                        state_d   = S_RUN;
                        busy_d    = 1'b1;
                        is_div_d  = (i_op == OP_DIV);
                        sign_p_d  = i_p[WIDTH-1];
                        sign_q_d  = i_q[WIDTH-1];
                        ovf_d     = (i_op == OP_DIV) && (i_p == {1'b1, {(WIDTH-1){1'b0}}}) && (i_q == '1);
                        mag_b_d   = q_mag;
                        work_hi_d = '0;
                        work_lo_d = p_mag;
                        cnt_d     = '0;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        lo_d    = sc_lo;
                        hi_d    = sc_hi;
                        flags_d = sc_flags;
                    end
                end
            end
            S_RUN: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[WIDTH]) begin
                            work_hi_d = div_diff[WIDTH-1:0];
                            work_lo_d = {work_lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            work_hi_d = div_shift[WIDTH-1:0];
                            work_lo_d = {work_lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        work_hi_d = mul_sum[WIDTH:1];
                        work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + SHW'(1);
                    if (cnt_q == {SHW{1'b1}}) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                busy_d = 1'b0;
                if (i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        lo_d    = quo_fin;
                        hi_d    = rem_fin;
                        flags_d = {({rem_fin, quo_fin} == '0), 1'b0, ovf_q, quo_fin[WIDTH-1], 1'b0};
                    end else begin
                        lo_d    = prod_fin[WIDTH-1:0];
                        hi_d    = prod_fin[2*WIDTH-1:WIDTH];
                        flags_d = {(prod_fin == '0), 1'b0,
                                   (prod_fin[2*WIDTH-1:WIDTH] != {WIDTH{prod_fin[WIDTH-1]}}),
                                   prod_fin[2*WIDTH-1], 1'b0};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller state, registered outputs and iteration registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            flags_q   <= '0;
            is_div_q  <= 1'b0;
            sign_p_q  <= 1'b0;
            sign_q_q  <= 1'b0;
            ovf_q     <= 1'b0;
            mag_b_q   <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            flags_q   <= flags_d;
            is_div_q  <= is_div_d;
            sign_p_q  <= sign_p_d;
            sign_q_q  <= sign_q_d;
            ovf_q     <= ovf_d;
            mag_b_q   <= mag_b_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=16.
// Flags are packed {ZF, CF, OF, NF, DZ}.
module tb_alu_mc;

    localparam int W = 16;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_start;
    logic          i_flush;
    logic [3:0]    i_op;
    logic [W-1:0]  i_p;
    logic [W-1:0]  i_q;
    logic          o_busy;
    logic          o_done;
    logic [W-1:0]  o_lo;
    logic [W-1:0]  o_hi;
    logic [4:0]    o_flags;

    int checks = 0;
    int errors = 0;
    int cyc;
    int busyCnt;
    int doneCnt;

    alu_mc #(.WIDTH(W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_flush (i_flush),
        .i_op    (i_op),
        .i_p     (i_p),
        .i_q     (i_q),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_lo    (o_lo),
        .o_hi    (o_hi),
        .o_flags (o_flags)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Compare an observed value against the bench's expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present an op with i_start for exactly one rising edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] p, input logic [W-1:0] q);
        i_op    = op;
        i_p     = p;
        i_q     = q;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Count cycles after the start edge until o_done, with a bounded budget.
    task automatic waitDone(output int cycles, output int busyCycles);
        cycles     = 1;
        busyCycles = o_busy ? 1 : 0;
        while (!o_done && cycles < 40) begin
            tick();
            cycles++;
            if (o_busy) busyCycles++;
        end
    endtask

    // Start an op, wait for completion and check latency, results and flags.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [W-1:0] p, input logic [W-1:0] q,
                         input int expCycles, input logic [W-1:0] expLo, input logic [W-1:0] expHi,
                         input logic [4:0] expFlags);
        applyStimulus(op, p, q);
        waitDone(cyc, busyCnt);
        checkOutput({tag, "_latency"}, cyc, expCycles);
        checkOutput({tag, "_lo"}, o_lo, expLo);
        checkOutput({tag, "_hi"}, o_hi, expHi);
        checkOutput({tag, "_flags"}, o_flags, expFlags);
        tick();
        checkOutput({tag, "_done_pulse"}, o_done, 1'b0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_flush = 1'b0;
        i_op    = 4'd0;
        i_p     = '0;
        i_q     = '0;
        tick();
        tick();
        checkOutput("reset_busy", o_busy, 1'b0);
        checkOutput("reset_done", o_done, 1'b0);
        checkOutput("reset_lo", o_lo, 16'h0000);
        checkOutput("reset_flags", o_flags, 5'b00000);
        i_rst_n = 1'b1;
        tick();

        // ADD overflow: single cycle, busy never raised.
        applyStimulus(4'd0, 16'h7FFF, 16'h0001);
        waitDone(cyc, busyCnt);
        checkOutput("add_latency", cyc, 1);
        checkOutput("add_busy_cycles", busyCnt, 0);
        checkOutput("add_lo", o_lo, 16'h8000);
        checkOutput("add_hi", o_hi, 16'h0000);
        checkOutput("add_flags", o_flags, 5'b00110);
        tick();

        // MUL -3*5: 17 busy cycles then done at cycle 18.
        applyStimulus(4'd2, 16'hFFFD, 16'h0005);
        waitDone(cyc, busyCnt);
        checkOutput("mul_neg_latency", cyc, 18);
        checkOutput("mul_neg_busy_cycles", busyCnt, 17);
        checkOutput("mul_neg_lo", o_lo, 16'hFFF1);
        checkOutput("mul_neg_hi", o_hi, 16'hFFFF);
        checkOutput("mul_neg_flags", o_flags, 5'b00010);
        tick();

        runOp("mul_ovf",  4'd2, 16'h4000, 16'h0004, 18, 16'h0000, 16'h0001, 5'b00100);
        runOp("div_neg",  4'd8, 16'hFFF9, 16'h0002, 18, 16'hFFFD, 16'hFFFF, 5'b00010);
        runOp("div_zero", 4'd8, 16'h0005, 16'h0000, 1,  16'hFFFF, 16'h0005, 5'b00011);
        runOp("div_min",  4'd8, 16'h8000, 16'hFFFF, 18, 16'h8000, 16'h0000, 5'b00110);
        runOp("sub_borrow", 4'd1, 16'h0000, 16'h0001, 1, 16'hFFFF, 16'h0000, 5'b01010);
        runOp("and_zero", 4'd3, 16'hF0F0, 16'h0F0F, 1, 16'h0000, 16'h0000, 5'b10000);
        runOp("or",       4'd4, 16'hF000, 16'h000F, 1, 16'hF00F, 16'h0000, 5'b00010);
        runOp("not",      4'd5, 16'hAAAA, 16'h00FF, 1, 16'hFF00, 16'h0000, 5'b00010);
        runOp("illegal",  4'd9, 16'h1234, 16'h5678, 1, 16'h0000, 16'h0000, 5'b10000);
        runOp("shl_1",    4'd7, 16'h8001, 16'h0001, 1, 16'h0002, 16'h0000, 5'b01000);
        runOp("shl_w",    4'd7, 16'h0001, 16'h0010, 1, 16'h0000, 16'h0000, 5'b11000);
        runOp("shr_big",  4'd6, 16'h8000, 16'h0014, 1, 16'hFFFF, 16'h0000, 5'b01010);
        runOp("shr_4",    4'd6, 16'h8018, 16'h0004, 1, 16'hF801, 16'h0000, 5'b01010);
        runOp("shr_0",    4'd6, 16'h1234, 16'h0000, 1, 16'h1234, 16'h0000, 5'b00000);

        // Flush a MUL in its fifth RUN cycle; results of the SHR above must hold.
        applyStimulus(4'd2, 16'h4000, 16'h0004);
        repeat (4) tick();
        checkOutput("flush_busy_before", o_busy, 1'b1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        checkOutput("flush_busy_after", o_busy, 1'b0);
        checkOutput("flush_done", o_done, 1'b0);
        checkOutput("flush_lo_held", o_lo, 16'h1234);
        checkOutput("flush_hi_held", o_hi, 16'h0000);
        checkOutput("flush_flags_held", o_flags, 5'b00000);
        runOp("add_after_flush", 4'd0, 16'h0001, 16'h0002, 1, 16'h0003, 16'h0000, 5'b00000);
        doneCnt = 0;
        repeat (20) begin
            tick();
            if (o_done) doneCnt++;
        end
        checkOutput("flush_no_late_done", doneCnt, 0);

        // i_start raised during RUN must be ignored, with nothing queued.
        applyStimulus(4'd2, 16'hFFFD, 16'h0005);
        tick();
        tick();
        i_op    = 4'd0;
        i_p     = 16'h0001;
        i_q     = 16'h0001;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        waitDone(cyc, busyCnt);
        checkOutput("start_ignored_latency", cyc + 3, 18);
        checkOutput("start_ignored_lo", o_lo, 16'hFFF1);
        checkOutput("start_ignored_hi", o_hi, 16'hFFFF);
        doneCnt = 0;
        repeat (20) begin
            tick();
            if (o_done) doneCnt++;
        end
        checkOutput("start_ignored_no_queue", doneCnt, 0);

        // Asynchronous reset in the middle of a DIV clears outputs at once.
        applyStimulus(4'd8, 16'hFFF9, 16'h0002);
        repeat (5) tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", o_busy, 1'b0);
        checkOutput("async_rst_lo", o_lo, 16'h0000);
        checkOutput("async_rst_hi", o_hi, 16'h0000);
        checkOutput("async_rst_flags", o_flags, 5'b00000);
        tick();
        i_rst_n = 1'b1;
        doneCnt = 0;
        repeat (20) begin
            tick();
            if (o_done || o_busy) doneCnt++;
        end
        checkOutput("async_rst_idle", doneCnt, 0);

        // Back-to-back starts issued in DONE each give exactly one o_done.
        i_op    = 4'd0;
        i_p     = 16'h0001;
        i_q     = 16'h0001;
        i_start = 1'b1;
        tick();
        checkOutput("b2b_first_done", o_done, 1'b1);
        checkOutput("b2b_first_lo", o_lo, 16'h0002);
        i_p = 16'h0002;
        i_q = 16'h0002;
        tick();
        i_start = 1'b0;
        checkOutput("b2b_second_done", o_done, 1'b1);
        checkOutput("b2b_second_lo", o_lo, 16'h0004);
        runOp("b2b_mul", 4'd2, 16'h0003, 16'h0003, 18, 16'h0009, 16'h0000, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
